// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle sequencer for the RV32M operations in the execute stage.
//   Multiplies are held for MUL_CYCLES cycles. Divides/remainders run a restoring
//   shift-subtract divider that produces one quotient bit per cycle.
//
// Ports
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   start_i     request; op and operands valid this cycle
//   flush_i     kill the in-flight op (mispredict/trap); beats a same-cycle start
//   alu_ctrl_i  operation code. Bit 3 set marks an M op:
//                 8 MUL, 9 MULH, 10 MULHSU, 11 MULHU,
//                 12 DIV, 13 DIVU, 14 REM, 15 REMU.
//               Codes 0..7 belong to the single-cycle ALU and are ignored here.
//   a_i, b_i    rs1 / rs2 operands
//   busy_o      stall request to the hazard unit
//   done_o      one-cycle pulse; result_o valid
//   result_o    registered result, held until the next completion
//
// Build option
//   MULDIV_EARLY_OUT_EN: a dividend magnitude smaller than a nonzero divisor
//   magnitude completes on the fast path (quotient 0, remainder a).
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | nothing in flight
// S_MUL  | multiply in flight, counter MUL_CYCLES-1 down to 0
// S_DIV  | divide in flight, counter WIDTH-1 down to 0, one bit/cycle
// S_DONE | result valid for one cycle; a new start may be accepted

module muldiv_ctrl #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [3:0]       alu_ctrl_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;        // low opcode bits select the variant
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;      // divisor magnitude while dividing
    logic [WIDTH-1:0] quot_q, quot_d;    // dividend shifts out as quotient shifts in
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Decode of the incoming request
    logic             accept;
    logic             in_is_div, in_is_rem, in_signed;
    logic             in_a_neg, in_b_neg;
    logic [WIDTH-1:0] in_a_mag, in_b_mag;
    logic             b_zero, div_ovf, early_out, fast;
    logic [WIDTH-1:0] fast_res;

    assign accept    = start_i & alu_ctrl_i[3] & ~flush_i &
                       ((state_q == S_IDLE) | (state_q == S_DONE));
    assign in_is_div = alu_ctrl_i[2];
    assign in_is_rem = alu_ctrl_i[1];
    assign in_signed = ~alu_ctrl_i[0];
    assign in_a_neg  = in_signed & a_i[WIDTH-1];
    assign in_b_neg  = in_signed & b_i[WIDTH-1];
    assign in_a_mag  = in_a_neg ? -a_i : a_i;
    assign in_b_mag  = in_b_neg ? -b_i : b_i;
    assign b_zero    = (b_i == '0);
    assign div_ovf   = in_signed & (a_i == INT_MIN) & (b_i == '1);

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = ~b_zero & (in_a_mag < in_b_mag);
`else
    assign early_out = 1'b0;
`endif

    assign fast = in_is_div & (b_zero | div_ovf | early_out);

    always_comb begin
        fast_res = '0;
        if (b_zero) begin
            fast_res = in_is_rem ? a_i : '1;
        end else if (div_ovf) begin
            fast_res = in_is_rem ? '0 : INT_MIN;
        end else begin
            // early out: quotient 0, remainder is the dividend itself
            fast_res = in_is_rem ? a_i : '0;
        end
    end

    // Multiply datapath on the captured operands.
    // op_q: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
    logic                   mul_a_sgn, mul_b_sgn;
    logic [2*WIDTH-1:0]     mul_a_ext, mul_b_ext, mul_prod;
    logic [WIDTH-1:0]       mul_res;

    assign mul_a_sgn = (op_q != 2'b11);
    assign mul_b_sgn = ~op_q[1];
    assign mul_a_ext = {{WIDTH{mul_a_sgn & opa_q[WIDTH-1]}}, opa_q};
    assign mul_b_ext = {{WIDTH{mul_b_sgn & opb_q[WIDTH-1]}}, opb_q};
    assign mul_prod  = mul_a_ext * mul_b_ext;
    assign mul_res   = (op_q == 2'b00) ? mul_prod[WIDTH-1:0] : mul_prod[2*WIDTH-1:WIDTH];

    // One restoring divide step. The partial remainder is WIDTH+1 bits so the
    // borrow out of the trial subtraction lands in the top bit.
    logic [WIDTH:0]   div_shift, div_diff;
    logic [WIDTH-1:0] div_rem_nx, div_quot_nx, div_q_fin, div_r_fin, div_res;

    assign div_shift   = {rem_q, quot_q[WIDTH-1]};
    assign div_diff    = div_shift - {1'b0, opb_q};
    assign div_rem_nx  = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    assign div_quot_nx = {quot_q[WIDTH-2:0], ~div_diff[WIDTH]};
    assign div_q_fin   = qneg_q ? -div_quot_nx : div_quot_nx;
    assign div_r_fin   = rneg_q ? -div_rem_nx : div_rem_nx;
    assign div_res     = op_q[1] ? div_r_fin : div_q_fin;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (accept) begin
                        op_d = alu_ctrl_i[1:0];
                        if (fast) begin
                            state_d  = S_DONE;
                            result_d = fast_res;
                        end else if (in_is_div) begin
                            state_d = S_DIV;
                            cnt_d   = DIV_LOAD;
                            opa_d   = a_i;
                            opb_d   = in_b_mag;
                            quot_d  = in_a_mag;
                            rem_d   = '0;
                            qneg_d  = in_a_neg ^ in_b_neg;
                            rneg_d  = in_a_neg;
                        end else begin
                            state_d = S_MUL;
                            cnt_d   = MUL_LOAD;
                            opa_d   = a_i;
                            opb_d   = b_i;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == '0) begin
                        state_d  = S_DONE;
                        result_d = mul_res;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_DIV: begin
                    quot_d = div_quot_nx;
                    rem_d  = div_rem_nx;
                    if (cnt_q == '0) begin
                        state_d  = S_DONE;
                        result_d = div_res;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    // The accepting cycle stalls combinationally; DONE already releases the stall.
    assign busy_o   = (state_q == S_MUL) | (state_q == S_DIV) | accept;
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

    localparam int W  = 32;
    localparam int MC = 2;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_MUL    = 4'd8;
    localparam logic [3:0] OP_MULH   = 4'd9;
    localparam logic [3:0] OP_MULHSU = 4'd10;
    localparam logic [3:0] OP_MULHU  = 4'd11;
    localparam logic [3:0] OP_DIV    = 4'd12;
    localparam logic [3:0] OP_DIVU   = 4'd13;
    localparam logic [3:0] OP_REM    = 4'd14;
    localparam logic [3:0] OP_REMU   = 4'd15;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = W + 1;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [3:0]    alu_ctrl_i = '0;
    logic [W-1:0]  a_i = '0;
    logic [W-1:0]  b_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  result_o;

    muldiv_ctrl #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .flush_i    (flush_i),
        .alu_ctrl_i (alu_ctrl_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
        string        name;
    } exp_t;

    exp_t         exp_q[$];
    int           vectors = 0;
    int           errors = 0;
    logic [W-1:0] last_res = '0;
    int           free_cyc = 0;

    // Reference model: RV32M semantics from plain 64-bit / integer arithmetic.
    function automatic logic [W-1:0] ref_res(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
        int                 sa, sb;
        logic signed [63:0] sa64, sb64, ua64, ub64, p;
        logic               ovf;
        sa   = $signed(a);
        sb   = $signed(b);
        sa64 = 64'(sa);
        sb64 = 64'(sb);
        ua64 = {32'h0, a};
        ub64 = {32'h0, b};
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_MUL:    begin p = sa64 * sb64; return p[31:0];  end
            OP_MULH:   begin p = sa64 * sb64; return p[63:32]; end
            OP_MULHSU: begin p = sa64 * ub64; return p[63:32]; end
            OP_MULHU:  begin p = ua64 * ub64; return p[63:32]; end
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return sa / sb;
            end
            OP_REM: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return sa % sb;
            end
            OP_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            OP_REMU: begin
                if (b == 0) return a;
                return a % b;
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic int lat_of(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
        logic         sgn;
        logic [W-1:0] ma, mb;
        if (op < OP_DIV) return MC + 1;
        if (b == 0) return 1;
        sgn = (op == OP_DIV) || (op == OP_REM);
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        ma = (sgn && $signed(a) < 0) ? -a : a;
        mb = (sgn && $signed(b) < 0) ? -b : b;
        if (ma < mb) return EARLY_LAT;
        return W + 1;
    endfunction

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compare every done pulse against the scoreboard, and check the
    // result register holds between completions.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (done_o) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done: cycle %0d result %h, no completion required", cyc, result_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (result_o !== e.res || cyc != e.cyc) begin
                            errors++;
                            $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                                     e.name, result_o, cyc, e.res, e.cyc);
                        end
                        last_res = e.res;
                    end
                end else begin
                    vectors++;
                    if (result_o !== last_res) begin
                        errors++;
                        $display("FAIL result_hold: cycle %0d result %h, required %h", cyc, result_o, last_res);
                    end
                    if (exp_q.size() != 0 && cyc >= exp_q[0].cyc) begin
                        e = exp_q.pop_front();
                        errors++;
                        $display("FAIL %s: no done at cycle %0d, required %h", e.name, e.cyc, e.res);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_idle();
        start_i    = 1'b0;
        flush_i    = 1'b0;
        alu_ctrl_i = 4'($urandom_range(0, 15));
        a_i        = $urandom;
        b_i        = $urandom;
    endtask

    task automatic check_busy(input logic exp, input string nm);
        #1;
        vectors++;
        if (busy_o !== exp) begin
            errors++;
            $display("FAIL %s: cycle %0d busy %b, required %b", nm, cyc, busy_o, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input int el, input string nm);
        start_i    = 1'b1;
        flush_i    = 1'b0;
        alu_ctrl_i = op;
        a_i        = a;
        b_i        = b;
        exp_q.push_back('{er, cyc + el, nm});
        free_cyc = cyc + el;
        check_busy(1'b1, {nm, "_busy_accept"});
    endtask

    task automatic issue_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(op, a, b, ref_res(op, a, b), lat_of(op, a, b), "random_op");
    endtask

    // Advance to the completing cycle; in between, pound on start with M ops
    // and scrambled operands, all of which must be ignored.
    task automatic run_to_free();
        do begin
            tick();
            if (cyc < free_cyc) begin
                start_i    = 1'($urandom_range(0, 1));
                flush_i    = 1'b0;
                alu_ctrl_i = 4'(8 + $urandom_range(0, 7));
                a_i        = $urandom;
                b_i        = $urandom;
                check_busy(1'b1, "busy_in_flight");
            end else begin
                drive_idle();
            end
        end while (cyc < free_cyc);
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        int           lat;
        string        name;
    } dir_t;

    dir_t dir_tab[$];

    initial begin
        int c0;

        dir_tab.push_back('{OP_DIV,    32'd100,        32'd7,          32'd14,         W + 1, "div_100_7"});
        dir_tab.push_back('{OP_REM,    32'd100,        32'd7,          32'd2,          W + 1, "rem_100_7"});
        dir_tab.push_back('{OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  W + 1, "rem_m7_2"});
        dir_tab.push_back('{OP_DIVU,   32'hFFFF_FFFE,  32'd2,          32'h7FFF_FFFF,  W + 1, "divu_big_2"});
        dir_tab.push_back('{OP_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF,  1,     "divu_by_zero"});
        dir_tab.push_back('{OP_REMU,   32'd5,          32'd0,          32'd5,          1,     "remu_by_zero"});
        dir_tab.push_back('{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,     "div_overflow"});
        dir_tab.push_back('{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1,     "rem_overflow"});
        dir_tab.push_back('{OP_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  MC + 1, "mulh_min_min"});
        dir_tab.push_back('{OP_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  MC + 1, "mulhsu_m1_2"});
        dir_tab.push_back('{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  MC + 1, "mulhu_max"});
        dir_tab.push_back('{OP_MUL,    32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  MC + 1, "mul_m3_5"});
        dir_tab.push_back('{OP_DIVU,   32'd3,          32'd10,         32'd0,          EARLY_LAT, "divu_small"});
        dir_tab.push_back('{OP_REM,    32'hFFFF_FFFD,  32'd10,         32'hFFFF_FFFD,  EARLY_LAT, "rem_small_neg"});
        dir_tab.push_back('{OP_DIV,    32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  W + 1, "div_m100_7"});

        // Reset state
        drive_idle();
        rst_ni = 1'b0;
        repeat (3) tick();
        vectors += 3;
        if (busy_o !== 1'b0)   begin errors++; $display("FAIL reset_busy: busy %b, required 0", busy_o); end
        if (done_o !== 1'b0)   begin errors++; $display("FAIL reset_done: done %b, required 0", done_o); end
        if (result_o !== '0)   begin errors++; $display("FAIL reset_result: result %h, required 0", result_o); end
        rst_ni = 1'b1;
        tick();
        drive_idle();
        free_cyc = cyc;

        // Directed cases, issued back-to-back in each DONE cycle
        check_busy(1'b0, "busy_idle");
        foreach (dir_tab[i]) begin
            issue(dir_tab[i].op, dir_tab[i].a, dir_tab[i].b, dir_tab[i].res, dir_tab[i].lat, dir_tab[i].name);
            run_to_free();
            check_busy(1'b0, {dir_tab[i].name, "_busy_done"});
        end
        tick();
        drive_idle();

        // Non-M op is ignored
        start_i    = 1'b1;
        alu_ctrl_i = OP_ADD;
        check_busy(1'b0, "non_m_start");
        tick();
        drive_idle();
        check_busy(1'b0, "non_m_after");

        // flush together with start: flush wins
        start_i    = 1'b1;
        flush_i    = 1'b1;
        alu_ctrl_i = OP_DIV;
        a_i        = 32'd100;
        b_i        = 32'd7;
        check_busy(1'b0, "flush_with_start");
        tick();
        drive_idle();
        check_busy(1'b0, "flush_start_dropped");

        // Flush in cycle 10 of a divide, then MUL 6*7 in cycle 11
        start_i    = 1'b1;
        alu_ctrl_i = OP_DIV;
        a_i        = 32'd100;
        b_i        = 32'd7;
        c0 = cyc;
        check_busy(1'b1, "flush_div_accept");
        repeat (10) begin
            tick();
            drive_idle();
        end
        flush_i = 1'b1;
        check_busy(1'b1, "flush_cycle_busy");
        tick();
        drive_idle();
        check_busy(1'b0, "after_flush_idle");
        vectors++;
        if (cyc != c0 + 11) begin
            errors++;
            $display("FAIL flush_timing: cycle %0d, required %0d", cyc, c0 + 11);
        end
        issue(OP_MUL, 32'd6, 32'd7, 32'd42, 3, "mul_6_7_after_flush");
        run_to_free();
        tick();
        drive_idle();

        // Reset mid-divide
        issue(OP_DIV, 32'd100, 32'd7, 32'd14, W + 1, "div_reset_victim");
        repeat (6) begin
            tick();
            drive_idle();
        end
        #1;
        rst_ni = 1'b0;
        #1;
        vectors += 3;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL midreset_busy: busy %b, required 0", busy_o); end
        if (done_o !== 1'b0) begin errors++; $display("FAIL midreset_done: done %b, required 0", done_o); end
        if (result_o !== '0) begin errors++; $display("FAIL midreset_result: result %h, required 0", result_o); end
        exp_q.delete();
        last_res = '0;
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
        drive_idle();
        free_cyc = cyc;

        // Randomized traffic against the reference model
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0: begin
                    check_busy(1'b0, "busy_idle_rand");
                    tick();
                    drive_idle();
                end
                1: begin
                    start_i    = 1'b1;
                    alu_ctrl_i = 4'($urandom_range(0, 7));
                    check_busy(1'b0, "non_m_rand");
                    tick();
                    drive_idle();
                end
                default: begin
                    issue_model(4'(8 + $urandom_range(0, 7)), rand_opnd(), rand_opnd());
                    run_to_free();
                end
            endcase
        end

        // Drain outstanding completions
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
            tick();
            drive_idle();
        end
        if (exp_q.size() != 0) begin
            errors++;
            vectors++;
            $display("FAIL drain_timeout: %0d completions outstanding, required 0", exp_q.size());
        end
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Multi-cycle sequencer for RV32M operations in the execute stage. It takes over MUL/MULH/MULHU/MULHSU/DIV/DIVU/REM/REMU from the single-cycle ALU path. Division runs as an iterative restoring shift-subtract, one quotient bit per cycle; multiply is held for a fixed number of cycles. Busy drives the hazard unit to stall IF/ID/EX; done/result feed the EX/MEM register.

Parameters:
WIDTH, 32, operand/result width (from all_pkgs)
MUL_CYCLES, 2, cycles a multiply occupies before done (legal 1..4)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; op/operands valid this cycle
flush  in  1  kill in-flight op (branch mispredict/trap)
alu_ctrl  in  ALU_OP  operation code (all_pkgs ALU_* encoding)
a  in  WIDTH  rs1 operand
b  in  WIDTH  rs2 operand
busy  out  1  stall request to hazard unit
done  out  1  one-cycle pulse, result valid
result  out  WIDTH  registered result, held until next completion

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, busy=0, done=0, result=0, all internal registers 0.
- States:
  - IDLE: no operation in flight.
  - MUL: counter loads MUL_CYCLES-1 and decrements to 0, then moves to DONE.
  - DIV: counter runs WIDTH iterations (WIDTH-1 down to 0), then moves to DONE.
  - DONE: lasts exactly 1 cycle, then moves to IDLE unless a new start is accepted.
- Acceptance:
  - start is accepted only in IDLE or DONE, only when alu_ctrl is an M op, and only when flush=0.
  - start with a non-M op is ignored: no state change, busy=0.
  - start in MUL or DIV is ignored.
- Operand capture: operands and op are latched on the acceptance edge. a/b may change afterwards without effect.
- Latency, counted from acceptance in cycle 0:
  - MUL*: done in cycle MUL_CYCLES+1.
  - DIV*/REM* normal path: done in cycle WIDTH+1 (33 at default).
- busy:
  - Combinational 1 in the accepting cycle.
  - 1 throughout MUL and DIV.
  - 0 in DONE and IDLE.
  - Stall releases in the same cycle done rises.
- done: high only in DONE. result updates on the edge entering DONE.
- Multiply:
  - Full 2*WIDTH product.
  - MUL: low half, signed×signed.
  - MULH: high half, signed×signed.
  - MULHU: high half, unsigned×unsigned.
  - MULHSU: high half, signed a × unsigned b.
- Divide:
  - Signed ops divide magnitudes.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Quotient and remainder registers are WIDTH bits; partial remainder is WIDTH+1 bits.
- Fast paths (decided at acceptance; go straight to DONE, done in cycle 1):
  - b==0: DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow, a=0x80000000 and b=-1: DIV → 0x80000000; REM → 0.
- flush:
  - Forces IDLE on the next edge from any state.
  - No done pulse; result unchanged.
  - flush with start in the same cycle: flush wins, start is dropped.
- Reset mid-operation: immediate return to reset values; no done pulse.
- Back-to-back: a start accepted in DONE enters MUL/DIV directly. The done pulse of the completing op is still emitted in that cycle.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: an unsigned/magnitude dividend smaller than the divisor (nonzero divisor) takes a fast path with done in cycle 1. Quotient is 0, remainder is a; REM keeps a's sign.
- Undefined: these cases run the full WIDTH iterations with identical results.

Test Plan:
1. DIV a=100 b=7, start in cycle 0 → busy 1 in cycles 0..32; done=1 and result=14 in cycle 33 (WIDTH=32); REM same operands → 2.
2. REM a=-7 (0xFFFFFFF9) b=2 → result 0xFFFFFFFF; DIVU a=0xFFFFFFFE b=2 → 0x7FFFFFFF.
3. DIVU a=5 b=0 → done in cycle 1, result 0xFFFFFFFF. REMU same operands → 5. DIV a=0x80000000 b=0xFFFFFFFF → 0x80000000 in cycle 1.
4. MULH a=b=0x80000000 → 0x40000000 in cycle 3 (MUL_CYCLES=2). MULHSU a=-1 b=2 → 0xFFFFFFFF. MUL a=-3 b=5 → 0xFFFFFFF1.
5. Flush in cycle 10 of DIV 100/7 → IDLE in cycle 11, no done, result unchanged. A new MUL 6×7 started in cycle 11 → 42 in cycle 14. Reset asserted mid-DIV → busy/done/result 0 immediately.
6. start with ALU_ADD → ignored, busy 0. start during DIV → ignored. With MULDIV_EARLY_OUT_EN: DIVU 3/10 → done in cycle 1, result 0; without it → cycle 33.
